// File: rtl/gemm_kernel_seq.sv
`timescale 1ns/1ps
// gemm_kernel_seq
// Sequences one GEMM multiply-accumulate batch: walks the source/parameter
// buffers row by row, drives the 4-lane MAC accumulator controls through a
// PIPE-deep delay line that matches the buffer read latency, hands each
// finished row to the output controller (k_fin_o) and flags batch end (s_fin_o).
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   run_i           batch enable; low aborts and holds idle
//   s_init_i        start pulse (source buffer full)
//   out_busy_i      output controller is draining accumulators
//   src_re_o/ra_o   source buffer read enable / address (row*N_K + k)
//   prm_re_o/ra_o   parameter bank read enable / address (k)
//   acc_clr_o       MAC lanes load product instead of accumulating
//   acc_en_o        MAC lanes update
//   k_fin_o         pulse: current row's accumulators are final
//   s_fin_o         pulse: batch complete
//   busy_o          batch in progress
//   overrun_o       sticky: start pulse arrived while busy
module gemm_kernel_seq #(
  parameter int N_ROW = 4,
  parameter int N_K   = 8,
  parameter int PIPE  = 1,
  localparam int AW = (N_ROW * N_K > 1) ? $clog2(N_ROW * N_K) : 1,
  localparam int KW = (N_K > 1) ? $clog2(N_K) : 1,
  localparam int RW = (N_ROW > 1) ? $clog2(N_ROW) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_i,
  input  logic          s_init_i,
  input  logic          out_busy_i,
  output logic          src_re_o,
  output logic [AW-1:0] src_ra_o,
  output logic          prm_re_o,
  output logic [KW-1:0] prm_ra_o,
  output logic          acc_clr_o,
  output logic          acc_en_o,
  output logic          k_fin_o,
  output logic          s_fin_o,
  output logic          busy_o,
  output logic          overrun_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, WAIT_OUT} state_t;

  state_t          state_q;
  logic [KW-1:0]   k_q;        // k of the read currently presented on the ports
  logic [RW-1:0]   row_q;
  logic [AW-1:0]   src_ra_q;
  logic            src_re_q;
  logic            first_q;    // first WAIT_OUT cycle: out_busy not yet valid
  logic            k_fin_q, s_fin_q, busy_q, overrun_q;
  logic [PIPE:1]   en_dl_q, clr_dl_q;
  logic [PIPE:0]   vld_pipe, clr_pipe;

  // Stage 0 is the read issued this cycle; stage PIPE is what the MAC sees.
  assign vld_pipe = {en_dl_q, src_re_q};
  assign clr_pipe = {clr_dl_q, src_re_q && (k_q == '0)};

  always_ff @(posedge clk) begin
    if (reset || !run_i) begin
      state_q  <= IDLE;
      k_q      <= '0;
      row_q    <= '0;
      src_ra_q <= '0;
      src_re_q <= 1'b0;
      first_q  <= 1'b0;
      k_fin_q  <= 1'b0;
      s_fin_q  <= 1'b0;
      busy_q   <= 1'b0;
      en_dl_q  <= '0;
      clr_dl_q <= '0;
      if (reset) overrun_q <= 1'b0;
    end else begin
      en_dl_q  <= vld_pipe[PIPE-1:0];
      clr_dl_q <= clr_pipe[PIPE-1:0];
      k_fin_q  <= 1'b0;
      s_fin_q  <= 1'b0;
      if (s_init_i && state_q != IDLE) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          busy_q <= s_init_i;
          if (s_init_i) begin
            state_q  <= RUN;
            row_q    <= '0;
            k_q      <= '0;
            src_ra_q <= '0;
            src_re_q <= 1'b1;
          end
        end
        RUN: begin
          if (k_q == KW'(N_K - 1)) begin
            state_q  <= DRAIN;
            src_re_q <= 1'b0;
          end else begin
            k_q      <= k_q + KW'(1);
            src_ra_q <= src_ra_q + AW'(1);
          end
        end
        DRAIN: begin
          // Nothing left in flight ahead of the MAC stage: the acc_en now
          // leaving the line is the row's last, so k_fin follows it.
          if (vld_pipe[PIPE-1:0] == '0) begin
            state_q <= WAIT_OUT;
            k_fin_q <= 1'b1;
            first_q <= 1'b1;
          end
        end
        WAIT_OUT: begin
          first_q <= 1'b0;
          if (!first_q && !out_busy_i) begin
            if (row_q == RW'(N_ROW - 1)) begin
              // busy stays high alongside s_fin; it drops from IDLE next cycle
              state_q <= IDLE;
              s_fin_q <= 1'b1;
            end else begin
              state_q  <= RUN;
              row_q    <= row_q + RW'(1);
              k_q      <= '0;
              src_ra_q <= src_ra_q + AW'(1);  // continues into next row's block
              src_re_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign src_re_o  = src_re_q;
  assign src_ra_o  = src_ra_q;
  assign prm_re_o  = src_re_q;
  assign prm_ra_o  = k_q;
  assign acc_en_o  = en_dl_q[PIPE];
  assign acc_clr_o = clr_dl_q[PIPE];
  assign k_fin_o   = k_fin_q;
  assign s_fin_o   = s_fin_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_gemm_kernel_seq.sv
`timescale 1ns/1ps
// Bench for gemm_kernel_seq: a PIPE=1 and a PIPE=3 instance share run/s_init,
// each with its own out_busy model (4 busy cycles after every k_fin).
module tb_gemm_kernel_seq;

  logic clk = 1'b0;
  logic reset, run, s_init;
  logic ob1, ob3;
  logic       re1, pre1, clr1, en1, kf1, sf1, bsy1, ovr1;
  logic [4:0] ra1;
  logic [2:0] pra1;
  logic       re3, pre3, clr3, en3, kf3, sf3, bsy3, ovr3;
  logic [4:0] ra3;
  logic [2:0] pra3;

  always #5 clk = ~clk;

  gemm_kernel_seq #(.N_ROW(4), .N_K(8), .PIPE(1)) dut1 (
    .clk(clk), .reset(reset), .run_i(run), .s_init_i(s_init), .out_busy_i(ob1),
    .src_re_o(re1), .src_ra_o(ra1), .prm_re_o(pre1), .prm_ra_o(pra1),
    .acc_clr_o(clr1), .acc_en_o(en1), .k_fin_o(kf1), .s_fin_o(sf1),
    .busy_o(bsy1), .overrun_o(ovr1));

  gemm_kernel_seq #(.N_ROW(4), .N_K(8), .PIPE(3)) dut3 (
    .clk(clk), .reset(reset), .run_i(run), .s_init_i(s_init), .out_busy_i(ob3),
    .src_re_o(re3), .src_ra_o(ra3), .prm_re_o(pre3), .prm_ra_o(pra3),
    .acc_clr_o(clr3), .acc_en_o(en3), .k_fin_o(kf3), .s_fin_o(sf3),
    .busy_o(bsy3), .overrun_o(ovr3));

  int cyc = 0, base = 0;
  int nchk = 0, nfail = 0;
  int stall_row = -1;
  int kf1_idx = 0, cnt1 = 0, cnt3 = 0;
  logic kf1_seen = 1'b0, kf3_seen = 1'b0;
  int lg1 [0:8][0:79];   // re, ra, prm, clr, en, kf, sf, busy, overrun
  int lg3 [0:8][0:79];
  int li;

  always @(posedge clk) cyc++;

  // Output-controller models: out_busy rises the cycle after k_fin.
  always @(negedge clk) begin
    kf1_seen = kf1;
    kf3_seen = kf3;
  end
  always @(posedge clk) begin
    #1;
    if (kf1_seen) begin
      cnt1 = (kf1_idx == stall_row) ? 20 : 4;
      kf1_idx++;
    end
    ob1 = (cnt1 > 0);
    if (cnt1 > 0) cnt1--;
    if (kf3_seen) cnt3 = 4;
    ob3 = (cnt3 > 0);
    if (cnt3 > 0) cnt3--;
  end

  always @(negedge clk) begin
    li = cyc - base;
    if (li >= 0 && li < 80) begin
      lg1[0][li] = re1;  lg1[1][li] = ra1; lg1[2][li] = pra1; lg1[3][li] = clr1;
      lg1[4][li] = en1;  lg1[5][li] = kf1; lg1[6][li] = sf1;  lg1[7][li] = bsy1;
      lg1[8][li] = ovr1;
      lg3[0][li] = re3;  lg3[1][li] = ra3; lg3[2][li] = pra3; lg3[3][li] = clr3;
      lg3[4][li] = en3;  lg3[5][li] = kf3; lg3[6][li] = sf3;  lg3[7][li] = bsy3;
      lg3[8][li] = ovr3;
    end
  end

  task automatic cmp(input string nm, input int c, input int act, input int exp);
    if (exp < 0) return;
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, c, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc - base < c) tick();
  endtask

  task automatic start_batch();
    for (int s = 0; s < 9; s++)
      for (int c = 0; c < 80; c++) begin
        lg1[s][c] = 0;
        lg3[s][c] = 0;
      end
    base = cyc;
    kf1_idx = 0;
    s_init = 1'b1;
    tick();
    s_init = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // count of cycles in [a,b] where signal s of dut1 log is high
  function automatic int cnt_hi1(input int s, input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) n += lg1[s][c];
    return n;
  endfunction
  function automatic int cnt_hi3(input int s, input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) n += lg3[s][c];
    return n;
  endfunction

  typedef struct {
    int c; int re; int ra; int prm; int clr; int en; int kf; int sf; int bsy;
  } vec_t;   // -1 = don't care

  vec_t tab1 [19];
  vec_t tab3 [17];
  string sn [0:7];

  initial begin
    sn = '{"re", "ra", "prm", "clr", "en", "kfin", "sfin", "busy"};
    //           c  re  ra prm clr en kf sf bsy
    tab1[0]  = '{ 0, 0,  0,  0, 0, 0, 0, 0, 0};
    tab1[1]  = '{ 1, 1,  0,  0, 0, 0, 0, 0, 1};
    tab1[2]  = '{ 2, 1,  1,  1, 1, 1, 0, 0, 1};
    tab1[3]  = '{ 8, 1,  7,  7, 0, 1, 0, 0, 1};
    tab1[4]  = '{ 9, 0, -1, -1, 0, 1, 0, 0, 1};
    tab1[5]  = '{10, 0, -1, -1, 0, 0, 1, 0, 1};
    tab1[6]  = '{11, 0, -1, -1, 0, 0, 0, 0, 1};
    tab1[7]  = '{15, 0, -1, -1, 0, 0, 0, 0, 1};
    tab1[8]  = '{16, 1,  8,  0, 0, 0, 0, 0, 1};
    tab1[9]  = '{17, 1,  9,  1, 1, 1, 0, 0, 1};
    tab1[10] = '{25, 0, -1, -1, 0, 0, 1, 0, 1};
    tab1[11] = '{31, 1, 16,  0, 0, 0, 0, 0, 1};
    tab1[12] = '{46, 1, 24,  0, 0, 0, 0, 0, 1};
    tab1[13] = '{53, 1, 31,  7, 0, 1, 0, 0, 1};
    tab1[14] = '{54, 0, -1, -1, 0, 1, 0, 0, 1};
    tab1[15] = '{55, 0, -1, -1, 0, 0, 1, 0, 1};
    tab1[16] = '{60, 0, -1, -1, 0, 0, 0, 0, 1};
    tab1[17] = '{61, 0, -1, -1, 0, 0, 0, 1, 1};
    tab1[18] = '{62, 0, -1, -1, 0, 0, 0, 0, 0};

    tab3[0]  = '{ 0, 0,  0,  0, 0, 0, 0, 0, 0};
    tab3[1]  = '{ 1, 1,  0,  0, 0, 0, 0, 0, 1};
    tab3[2]  = '{ 3, 1,  2,  2, 0, 0, 0, 0, 1};
    tab3[3]  = '{ 4, 1,  3,  3, 1, 1, 0, 0, 1};
    tab3[4]  = '{ 8, 1,  7,  7, 0, 1, 0, 0, 1};
    tab3[5]  = '{ 9, 0, -1, -1, 0, 1, 0, 0, 1};
    tab3[6]  = '{11, 0, -1, -1, 0, 1, 0, 0, 1};
    tab3[7]  = '{12, 0, -1, -1, 0, 0, 1, 0, 1};
    tab3[8]  = '{17, 0, -1, -1, 0, 0, 0, 0, 1};
    tab3[9]  = '{18, 1,  8,  0, 0, 0, 0, 0, 1};
    tab3[10] = '{21, 1, 11,  3, 1, 1, 0, 0, 1};
    tab3[11] = '{25, 1, 15,  7, 0, 1, 0, 0, 1};
    tab3[12] = '{52, 1, 24,  0, 0, 0, 0, 0, 1};
    tab3[13] = '{59, 1, 31,  7, 0, 1, 0, 0, 1};
    tab3[14] = '{63, 0, -1, -1, 0, 0, 1, 0, 1};
    tab3[15] = '{69, 0, -1, -1, 0, 0, 0, 1, 1};
    tab3[16] = '{70, 0, -1, -1, 0, 0, 0, 0, 0};

    reset = 1'b1; run = 1'b0; s_init = 1'b0;
    tick(); tick(); tick();

    // reset state
    @(negedge clk);
    cmp("rst.busy", cyc, bsy1, 0);
    cmp("rst.src_re", cyc, re1, 0);
    cmp("rst.acc_en", cyc, en1, 0);
    cmp("rst.overrun", cyc, ovr1, 0);
    cmp("rst3.busy", cyc, bsy3, 0);
    @(posedge clk); #1;
    reset = 1'b0; run = 1'b1;
    tick();

    // nominal batch, both PIPE values
    start_batch();
    wait_to(72);
    foreach (tab1[i]) begin
      int ex [0:7];
      ex = '{tab1[i].re, tab1[i].ra, tab1[i].prm, tab1[i].clr,
             tab1[i].en, tab1[i].kf, tab1[i].sf, tab1[i].bsy};
      for (int s = 0; s < 8; s++) cmp({"nom1.", sn[s]}, tab1[i].c, lg1[s][tab1[i].c], ex[s]);
    end
    foreach (tab3[i]) begin
      int ex [0:7];
      ex = '{tab3[i].re, tab3[i].ra, tab3[i].prm, tab3[i].clr,
             tab3[i].en, tab3[i].kf, tab3[i].sf, tab3[i].bsy};
      for (int s = 0; s < 8; s++) cmp({"nom3.", sn[s]}, tab3[i].c, lg3[s][tab3[i].c], ex[s]);
    end
    cmp("nom1.en_count", 0, cnt_hi1(4, 0, 71), 32);
    cmp("nom1.clr_count", 0, cnt_hi1(3, 0, 71), 4);
    cmp("nom1.kfin_count", 0, cnt_hi1(5, 0, 71), 4);
    cmp("nom1.sfin_count", 0, cnt_hi1(6, 0, 71), 1);
    cmp("nom3.en_count", 0, cnt_hi3(4, 0, 71), 32);
    cmp("nom3.sfin_count", 0, cnt_hi3(6, 0, 71), 1);
    cmp("nom1.overrun", 71, lg1[8][71], 0);

    // long out_busy stall after row1 k_fin (cycles 26..45)
    do_reset();
    stall_row = 1;
    start_batch();
    wait_to(79);
    cmp("stall.kfin", 25, lg1[5][25], 1);
    cmp("stall.en_during", 26, cnt_hi1(4, 26, 46), 0);
    cmp("stall.clr_during", 26, cnt_hi1(3, 26, 46), 0);
    cmp("stall.re_before", 46, lg1[0][46], 0);
    cmp("stall.re_resume", 47, lg1[0][47], 1);
    cmp("stall.ra_resume", 47, lg1[1][47], 16);
    cmp("stall.clr_resume", 48, lg1[3][48], 1);
    cmp("stall.sfin", 77, lg1[6][77], 1);
    cmp("stall.sfin_count", 0, cnt_hi1(6, 0, 78), 1);
    cmp("stall.busy_end", 78, lg1[7][78], 0);
    stall_row = -1;

    // s_init while busy
    do_reset();
    start_batch();
    wait_to(35);
    s_init = 1'b1;
    tick();
    s_init = 1'b0;
    wait_to(72);
    cmp("ovr.before", 35, lg1[8][35], 0);
    cmp("ovr.set", 36, lg1[8][36], 1);
    cmp("ovr.sticky", 71, lg1[8][71], 1);
    cmp("ovr.sfin", 61, lg1[6][61], 1);
    cmp("ovr.sfin_count", 0, cnt_hi1(6, 0, 71), 1);
    cmp("ovr.en_count", 0, cnt_hi1(4, 0, 71), 32);

    // run dropped at row1 k=3
    do_reset();
    start_batch();
    wait_to(19);
    run = 1'b0;
    tick();
    run = 1'b1;
    wait_to(41);
    cmp("abort.ra_k3", 19, lg1[1][19], 11);
    for (int s = 0; s < 9; s++) cmp("abort.outputs_zero", 20, lg1[s][20], 0);
    cmp("abort.en_after", 20, cnt_hi1(4, 20, 40), 0);
    cmp("abort.kfin_after", 20, cnt_hi1(5, 20, 40), 0);
    cmp("abort.sfin_after", 20, cnt_hi1(6, 20, 40), 0);
    cmp("abort.busy_after", 20, cnt_hi1(7, 20, 40), 0);
    start_batch();
    wait_to(4);
    cmp("restart.re", 1, lg1[0][1], 1);
    cmp("restart.ra", 1, lg1[1][1], 0);
    cmp("restart.clr", 2, lg1[3][2], 1);

    // reset while in WAIT_OUT with overrun set
    do_reset();
    start_batch();
    wait_to(4);
    s_init = 1'b1;
    tick();
    s_init = 1'b0;
    wait_to(12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_to(14);
    cmp("rstw.kfin_seen", 10, lg1[5][10], 1);
    cmp("rstw.ovr_before", 12, lg1[8][12], 1);
    for (int s = 0; s < 9; s++) cmp("rstw.outputs_zero", 13, lg1[s][13], 0);
    start_batch();
    wait_to(4);
    cmp("rstw.restart_re", 1, lg1[0][1], 1);
    cmp("rstw.restart_ra", 1, lg1[1][1], 0);
    cmp("rstw.restart_clr", 2, lg1[3][2], 1);
    cmp("rstw.ovr_clear", 2, lg1[8][2], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
